// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and chessboard geometry for vga_timing_gen.
package vga_timing_pkg;

    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned HS_START = 656;
    localparam int unsigned HS_END   = 751;
    localparam int unsigned VS_START = 490;
    localparam int unsigned VS_END   = 491;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned BOARD_X0_DEF  = 80;
    localparam int unsigned SQ_SIZE_DEF   = 60;

    localparam int unsigned CW = 10;

    typedef logic [CW-1:0] coord_t;

    typedef struct packed {
        logic [2:0] idx;
        logic [5:0] off;
    } sq_pos_t;

    function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_sq_tracker.sv
// Incremental square index/offset tracker for one axis; saturates at square 7, last offset.
module vga_sq_tracker
    import vga_timing_pkg::*;
#(
    parameter int unsigned START   = 0,
    parameter int unsigned SQ_SIZE = SQ_SIZE_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    input  coord_t  i_coord_next,
    input  logic    i_step,
    output sq_pos_t o_pos
);

    localparam coord_t     START_C  = coord_t'(START);
    localparam logic [5:0] LAST_OFF = 6'(SQ_SIZE - 1);

    sq_pos_t r_pos;
    logic    w_before;
    logic    w_restart;

    if (START > 0) begin : g_lead
        assign w_before = (i_coord_next < START_C);
    end else begin : g_no_lead
        assign w_before = 1'b0;
    end

    assign w_restart = (i_coord_next == '0) || (i_coord_next == START_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos <= '0;
        end else if (w_restart) begin
            r_pos <= '0;
        end else if (i_step && !w_before) begin
            if (r_pos.off != LAST_OFF) begin
                r_pos.off <= r_pos.off + 6'd1;
            end else if (r_pos.idx != 3'd7) begin
                // Past square 7 the position holds until the next restart.
                r_pos.idx <= r_pos.idx + 3'd1;
                r_pos.off <= '0;
            end
        end
    end

    assign o_pos = r_pos;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480 VGA raster timing with registered, zero-skew outputs.
// Square tracking for the 8x8 board is built only when VGA_SQUARE_COORD_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned BOARD_X0  = BOARD_X0_DEF,
    parameter int unsigned SQ_SIZE   = SQ_SIZE_DEF
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic [2:0] sq_col,
    output logic [2:0] sq_row,
    output logic [5:0] sq_px,
    output logic [5:0] sq_py,
    output logic       on_board
);

    if ((BOARD_X0 + 8 * SQ_SIZE > H_VISIBLE) || (8 * SQ_SIZE > V_VISIBLE) || (SQ_SIZE > 64))
    begin : g_geom_check
        $error("vga_timing_gen: board does not fit the visible area");
    end

    coord_t r_x;
    coord_t r_y;
    logic   r_blank;
    logic   r_hs;
    logic   r_vs;
    logic   r_frame_start;

    logic   w_x_wrap;
    coord_t w_x_next;
    coord_t w_y_next;

    always_comb begin
        w_x_wrap = (r_x == coord_t'(H_TOTAL - 1));
        w_x_next = w_x_wrap ? '0 : r_x + coord_t'(1);
        w_y_next = r_y;
        if (w_x_wrap) begin
            w_y_next = (r_y == coord_t'(V_TOTAL - 1)) ? '0 : r_y + coord_t'(1);
        end
    end

    // Every flag is computed from the next coordinates so it lands with them.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_blank       <= 1'b1;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_blank       <= (w_x_next < coord_t'(H_VISIBLE)) && (w_y_next < coord_t'(V_VISIBLE));
            r_hs          <= !in_range(w_x_next, coord_t'(HS_START), coord_t'(HS_END));
            r_vs          <= !in_range(w_y_next, coord_t'(VS_START), coord_t'(VS_END));
            r_frame_start <= (w_x_next == '0) && (w_y_next == '0);
        end
    end

    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign blank       = r_blank;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign frame_start = r_frame_start;

`ifdef VGA_SQUARE_COORD_EN
    localparam coord_t BOARD_X1 = coord_t'(BOARD_X0 + 8 * SQ_SIZE);
    localparam coord_t BOARD_Y1 = coord_t'(8 * SQ_SIZE);

    sq_pos_t w_hpos;
    sq_pos_t w_vpos;
    logic    r_on_board;

    vga_sq_tracker #(
        .START   (BOARD_X0),
        .SQ_SIZE (SQ_SIZE)
    ) u_h_trk (
        .clk          (vga_clk),
        .rst_n        (reset_n),
        .i_coord_next (w_x_next),
        .i_step       (1'b1),
        .o_pos        (w_hpos)
    );

    vga_sq_tracker #(
        .START   (0),
        .SQ_SIZE (SQ_SIZE)
    ) u_v_trk (
        .clk          (vga_clk),
        .rst_n        (reset_n),
        .i_coord_next (w_y_next),
        .i_step       (w_x_wrap),
        .o_pos        (w_vpos)
    );

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_on_board <= 1'b0;
        end else begin
            r_on_board <= (w_x_next >= coord_t'(BOARD_X0)) && (w_x_next < BOARD_X1) &&
                          (w_y_next < BOARD_Y1) &&
                          (w_x_next < coord_t'(H_VISIBLE)) && (w_y_next < coord_t'(V_VISIBLE));
        end
    end

    assign sq_col   = w_hpos.idx;
    assign sq_px    = w_hpos.off;
    assign sq_row   = w_vpos.idx;
    assign sq_py    = w_vpos.off;
    assign on_board = r_on_board;
`else
    assign sq_col   = '0;
    assign sq_px    = '0;
    assign sq_row   = '0;
    assign sq_py    = '0;
    assign on_board = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: cycle-exact reference model plus table and sequence checks.
// Square expectations follow VGA_SQUARE_COORD_EN (zero when undefined).
module tb_vga_timing_gen;

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] DrawX, DrawY;
    logic       blank, hs, vs, frame_start, on_board;
    logic [2:0] sq_col, sq_row;
    logic [5:0] sq_px, sq_py;

    vga_timing_gen dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .hs          (hs),
        .vs          (vs),
        .frame_start (frame_start),
        .sq_col      (sq_col),
        .sq_row      (sq_row),
        .sq_px       (sq_px),
        .sq_py       (sq_py),
        .on_board    (on_board)
    );

    always #20 vga_clk = ~vga_clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [2:0] col;
        logic [2:0] row;
        logic [5:0] px;
        logic [5:0] py;
        logic       on;
    } obs_t;

    int n_tests  = 0;
    int n_fail   = 0;
    int n_prints = 0;
    int n_cyc    = 0;
    bit chk_en   = 1'b0;

    // Cycles elapsed since reset was released; the whole raster is a function of it.
    always @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) n_cyc <= 0;
        else          n_cyc <= n_cyc + 1;
    end

    function automatic obs_t model(int n);
        obs_t e;
        int x, y;
        x = n % 800;
        y = (n / 800) % 525;
        e = '0;
        e.x     = 10'(x);
        e.y     = 10'(y);
        e.blank = (x < 640) && (y < 480);
        e.hs    = !((x >= 656) && (x <= 751));
        e.vs    = !((y >= 490) && (y <= 491));
        e.fs    = (n > 0) && (x == 0) && (y == 0);
`ifdef VGA_SQUARE_COORD_EN
        if (x < 80) begin
            e.col = 3'd0; e.px = 6'd0;
        end else if (x >= 560) begin
            e.col = 3'd7; e.px = 6'd59;
        end else begin
            e.col = 3'((x - 80) / 60); e.px = 6'((x - 80) % 60);
        end
        if (y >= 480) begin
            e.row = 3'd7; e.py = 6'd59;
        end else begin
            e.row = 3'(y / 60); e.py = 6'(y % 60);
        end
        e.on = (x >= 80) && (x < 560) && (y < 480);
`endif
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a = {DrawX, DrawY, blank, hs, vs, frame_start, sq_col, sq_row, sq_px, sq_py, on_board};
        return a;
    endfunction

    always @(negedge vga_clk) begin
        if (chk_en) begin
            obs_t a, e;
            a = sample();
            e = model(n_cyc);
            n_tests++;
            if (a !== e) begin
                n_fail++;
                if (n_prints < 10) begin
                    n_prints++;
                    $display("FAIL model n=%0d actual=%h expected=%h", n_cyc, a, e);
                end
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic wait_xy(input int y, input int x, input string nm);
        int k;
        k = 0;
        @(negedge vga_clk);
        while (!(DrawX == 10'(x) && DrawY == 10'(y)) && k < 500000) begin
            @(negedge vga_clk);
            k++;
        end
        if (k >= 500000) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout waiting for x=%0d y=%0d actual x=%0d y=%0d",
                     nm, x, y, DrawX, DrawY);
        end
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_x"}, int'(DrawX), 0);
        check({nm, "_y"}, int'(DrawY), 0);
        check({nm, "_blank"}, int'(blank), 1);
        check({nm, "_hs"}, int'(hs), 1);
        check({nm, "_vs"}, int'(vs), 1);
        check({nm, "_fs"}, int'(frame_start), 0);
        check({nm, "_sq"}, int'({sq_col, sq_row, sq_px, sq_py, on_board}), 0);
    endtask

    typedef struct {
        int x;
        int col;
        int px;
        int on;
        int hs;
        int blank;
    } vec_t;

    localparam int SQ_ON =
`ifdef VGA_SQUARE_COORD_EN
        1;
`else
        0;
`endif

    initial begin
        vec_t tbl[13];
        int hs_low, hs_first, blank_low5, vs_low, vs_first, vs_last, blank_low, fs_cnt;

        // Line 100 lies in board row 1 at offset 40.
        tbl[0]  = '{x: 0,   col: 0, px: 0,  on: 0, hs: 1, blank: 1};
        tbl[1]  = '{x: 79,  col: 0, px: 0,  on: 0, hs: 1, blank: 1};
        tbl[2]  = '{x: 80,  col: 0, px: 0,  on: 1, hs: 1, blank: 1};
        tbl[3]  = '{x: 139, col: 0, px: 59, on: 1, hs: 1, blank: 1};
        tbl[4]  = '{x: 140, col: 1, px: 0,  on: 1, hs: 1, blank: 1};
        tbl[5]  = '{x: 333, col: 4, px: 13, on: 1, hs: 1, blank: 1};
        tbl[6]  = '{x: 559, col: 7, px: 59, on: 1, hs: 1, blank: 1};
        tbl[7]  = '{x: 560, col: 7, px: 59, on: 0, hs: 1, blank: 1};
        tbl[8]  = '{x: 640, col: 7, px: 59, on: 0, hs: 1, blank: 0};
        tbl[9]  = '{x: 655, col: 7, px: 59, on: 0, hs: 1, blank: 0};
        tbl[10] = '{x: 656, col: 7, px: 59, on: 0, hs: 0, blank: 0};
        tbl[11] = '{x: 751, col: 7, px: 59, on: 0, hs: 0, blank: 0};
        tbl[12] = '{x: 752, col: 7, px: 59, on: 0, hs: 1, blank: 0};

        chk_en = 1'b1;
        repeat (3) @(negedge vga_clk);
        check_reset_vals("rst");
        #5 reset_n = 1'b1;
        @(negedge vga_clk);
        check("first_x", int'(DrawX), 1);
        check("first_y", int'(DrawY), 0);
        check("first_fs", int'(frame_start), 0);

        for (int i = 0; i < 13; i++) begin
            wait_xy(100, tbl[i].x, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_col", i), int'(sq_col), SQ_ON * tbl[i].col);
            check($sformatf("tbl%0d_px", i), int'(sq_px), SQ_ON * tbl[i].px);
            check($sformatf("tbl%0d_row", i), int'(sq_row), SQ_ON * 1);
            check($sformatf("tbl%0d_py", i), int'(sq_py), SQ_ON * 40);
            check($sformatf("tbl%0d_on", i), int'(on_board), SQ_ON * tbl[i].on);
            check($sformatf("tbl%0d_hs", i), int'(hs), tbl[i].hs);
            check($sformatf("tbl%0d_blank", i), int'(blank), tbl[i].blank);
        end

        // Mid-frame asynchronous reset while hs is low.
        wait_xy(300, 700, "midrst");
        check("pre_rst_hs", int'(hs), 0);
        #5 reset_n = 1'b0;
        #1 check_reset_vals("async_rst");
        repeat (2) @(negedge vga_clk);
        check_reset_vals("held_rst");
        #5 reset_n = 1'b1;

        hs_low = 0; hs_first = -1; blank_low5 = 0; vs_low = 0; vs_first = -1; vs_last = -1;
        blank_low = 0; fs_cnt = 0;
        for (int i = 0; i < 420000; i++) begin
            @(negedge vga_clk);
            if (DrawY == 10'd5 && !hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(DrawX);
            end
            if (DrawY == 10'd5 && !blank) blank_low5++;
            if (!vs) begin
                vs_low++;
                if (vs_first < 0) vs_first = int'(DrawY);
                vs_last = int'(DrawY);
            end
            if (!blank) blank_low++;
            if (frame_start) fs_cnt++;
        end
        check("wrap_x", int'(DrawX), 0);
        check("wrap_y", int'(DrawY), 0);
        check("wrap_fs", int'(frame_start), 1);
        check("fs_count", fs_cnt, 1);
        check("hs_low_cycles", hs_low, 96);
        check("hs_first_x", hs_first, 656);
        check("blank_low_line", blank_low5, 160);
        check("vs_low_cycles", vs_low, 1600);
        check("vs_first_y", vs_first, 490);
        check("vs_last_y", vs_last, 491);
        check("blank_low_frame", blank_low, 480 * 160 + 45 * 800);
        @(negedge vga_clk);
        check("post_wrap_fs", int'(frame_start), 0);

        // Random reset pulses; the free-running model checks every cycle.
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(1, 5000)) @(negedge vga_clk);
            #($urandom_range(2, 8)) reset_n = 1'b0;
            #1 check($sformatf("rnd_rst%0d_x", r), int'(DrawX), 0);
            repeat ($urandom_range(1, 4)) @(negedge vga_clk);
            #5 reset_n = 1'b1;
        end
        repeat (2000) @(negedge vga_clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-003 SHALL have parameter BOARD_X0, default 80, left pixel column of the 480x480 chessboard.
REQ-004 SHALL have parameter SQ_SIZE, default 60, square edge in pixels; board is 8*SQ_SIZE square, top row at DrawY=0.
REQ-005 SHALL have port vga_clk, input, 1, 25 MHz pixel clock; all state on rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port DrawX, output, 10, current pixel column, range 0..799.
REQ-008 SHALL have port DrawY, output, 10, current line, range 0..524.
REQ-009 SHALL have port blank, output, 1, high when the pixel is visible (DrawX<640 and DrawY<480); downstream sprite stages drive colour only when high.
REQ-010 SHALL have port hs, output, 1, horizontal sync, active low.
REQ-011 SHALL have port vs, output, 1, vertical sync, active low.
REQ-012 SHALL have port frame_start, output, 1, one-cycle pulse at DrawX=0, DrawY=0.
REQ-013 SHALL have ports sq_col, output, 3, and sq_row, output, 3, giving the board square under the pixel.
REQ-014 SHALL have ports sq_px, output, 6, and sq_py, output, 6, giving the pixel offset inside the square (0..SQ_SIZE-1).
REQ-015 SHALL have port on_board, output, 1, high when the pixel lies inside the board and blank is high.

Function
REQ-016 SHALL count DrawX 0..799 and wrap to 0; DrawY SHALL increment only on the DrawX 799->0 wrap and SHALL wrap 524->0.
REQ-017 SHALL drive hs low for DrawX 656..751 inclusive and high otherwise.
REQ-018 SHALL drive vs low for DrawY 490..491 inclusive and high otherwise.
REQ-019 SHALL drive every output from a register, with hs, vs, blank, frame_start and square outputs corresponding to the DrawX/DrawY values presented in the same cycle (zero relative skew).
REQ-020 SHALL track sq_px/sq_col incrementally without dividers: at DrawX=BOARD_X0 load sq_px=0, sq_col=0; sq_px increments each cycle; at SQ_SIZE-1 it wraps to 0 and sq_col increments.
REQ-021 SHALL hold sq_col=7, sq_px=SQ_SIZE-1 from DrawX=BOARD_X0+8*SQ_SIZE to the line end, and 0/0 before BOARD_X0.
REQ-022 SHALL advance sq_py/sq_row once per line on the DrawX wrap, using the same wrap rule; both SHALL return to 0 when DrawY wraps to 0, and SHALL hold 7/SQ_SIZE-1 for DrawY>=8*SQ_SIZE.
REQ-023 SHALL assert on_board only when BOARD_X0<=DrawX<BOARD_X0+8*SQ_SIZE and DrawY<8*SQ_SIZE.

Reset
REQ-024 SHALL, while reset_n is low, force DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_start=0, square outputs and on_board=0.
REQ-025 SHALL begin counting on the first vga_clk rising edge after reset_n rises, with DrawX=1 after that edge; frame_start SHALL NOT pulse for the reset frame.
REQ-026 SHALL abandon any partial frame on mid-frame reset and restart from 0,0 with no glitch pulse on hs or vs.

Configuration
REQ-027 SHALL compile the square-tracking logic (REQ-020..023) only when macro VGA_SQUARE_COORD_EN is defined; without it, sq_col, sq_row, sq_px, sq_py and on_board SHALL be tied to 0 and the ports SHALL remain present.

Structure
REQ-028 SHALL take H_TOTAL=800, V_TOTAL=525, HS_START=656, HS_END=751, VS_START=490, VS_END=491 and the board geometry defaults from package vga_timing_pkg.
REQ-029 SHALL place square tracking in one sub-module vga_sq_tracker, instantiated twice (horizontal and vertical axes).

Verification
REQ-030 SHALL cover: release reset, run 800*525 cycles -> DrawX/DrawY return to 0,0 and frame_start pulses exactly once at that point.
REQ-031 SHALL cover: line scan -> hs low for exactly 96 cycles starting at DrawX=656; blank low from DrawX=640 to 799.
REQ-032 SHALL cover: frame scan -> vs low for exactly 2 lines (490,491); blank low for DrawY 480..524.
REQ-033 SHALL cover (macro on): DrawX=80 -> sq_col=0, sq_px=0; DrawX=139 -> 0/59; DrawX=140 -> 1/0; DrawX=559 -> 7/59, on_board=1; DrawX=560 -> on_board=0.
REQ-034 SHALL cover: reset_n pulsed low at DrawX=700, DrawY=300 -> all outputs at reset values asynchronously, counting resumes from 0,0.
REQ-035 SHALL cover (macro off): full frame -> sq_* and on_board constant 0; timing outputs identical to macro-on run.
